// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Two-master arbiter/sequencer for the shared peripheral bus. Master 0 is
//   the CPU memory port and master 1 is the UART/DMA engine. The block
//   latches one request, runs exactly one bus transaction, and returns read
//   data with done/err to the granted master. The CPU has fixed priority.
//   DMA is forced to win after STARVE_MAX consecutive CPU wins while it is
//   waiting. Each transaction times out after TIMEOUT+1 WAIT cycles with no
//   bus_ready.
//
// Ports
//   clk, RSTN                  clock, asynchronous active-low reset
//   mN_req                     request; mN_* fields are held stable until mN_done
//   mN_addr/wdata/rd/we        request fields
//   mN_done                    1-cycle completion pulse
//   mN_err                     timeout or illegal request
//   mN_rdata                   read data; valid with mN_done
//   mN_err, mN_rdata           both hold until the next mN_done
//   bus_addr/wdata/rd/we       shared bus; driven only in ADDR/WAIT, otherwise 0
//   bus_ready, bus_rdata       slave handshake and read data
//   owner                      current/last granted master (0 CPU, 1 DMA)
module bus_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        RSTN,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_rd,
  input  logic [3:0]  m0_we,
  output logic        m0_done,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_rd,
  input  logic [3:0]  m1_we,
  output logic        m1_done,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_rd,
  output logic [3:0]  bus_we,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  output logic        owner
);

  localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX);
  localparam logic [7:0]    TMO_LAST    = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, RESP} state_t;

  state_t        state, state_nx;
  logic [31:0]   lat_addr, lat_wdata;
  logic          lat_rd;
  logic [3:0]    lat_we;
  logic [7:0]    tmo_cnt;
  logic [SW-1:0] starve_cnt;

  logic          grant_valid, grant_m1;
  logic [31:0]   win_addr, win_wdata;
  logic          win_rd, win_illegal;
  logic [3:0]    win_we;
  logic          resp_load, resp_m1, resp_err;
  logic [31:0]   resp_rdata;
  logic          drive;

  // Winner selection and next state. Responses are loaded on the edge that
  // enters RESP so that err/rdata are already valid while done is high.
  always_comb begin
    state_nx    = state;
    grant_valid = 1'b0;
    grant_m1    = m1_req && (!m0_req || starve_cnt == STARVE_LAST);
    win_addr    = grant_m1 ? m1_addr  : m0_addr;
    win_wdata   = grant_m1 ? m1_wdata : m0_wdata;
    win_rd      = grant_m1 ? m1_rd    : m0_rd;
    win_we      = grant_m1 ? m1_we    : m0_we;
    win_illegal = (!win_rd && win_we == 4'h0) || (win_rd && win_we != 4'h0);
    resp_load   = 1'b0;
    resp_m1     = owner;
    resp_err    = 1'b0;
    resp_rdata  = '0;
    unique case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant_valid = 1'b1;
          if (win_illegal) begin
            state_nx  = RESP;
            resp_load = 1'b1;
            resp_m1   = grant_m1;
            resp_err  = 1'b1;
          end else begin
            state_nx = ADDR;
          end
        end
      end
      ADDR: state_nx = WAIT;
      WAIT: begin
        if (bus_ready) begin
          state_nx   = RESP;
          resp_load  = 1'b1;
          resp_rdata = lat_rd ? bus_rdata : '0;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nx  = RESP;
          resp_load = 1'b1;
          resp_err  = 1'b1;
        end
      end
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state      <= IDLE;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_rd     <= 1'b0;
      lat_we     <= '0;
      tmo_cnt    <= '0;
      starve_cnt <= '0;
      owner      <= 1'b0;
      m0_err     <= 1'b0;
      m0_rdata   <= '0;
      m1_err     <= 1'b0;
      m1_rdata   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        if (grant_valid) begin
          lat_addr  <= win_addr;
          lat_wdata <= win_wdata;
          lat_rd    <= win_rd;
          lat_we    <= win_we;
          owner     <= grant_m1;
        end
        // Counts CPU wins that happened while DMA was waiting.
        if (!m1_req || (grant_valid && grant_m1))
          starve_cnt <= '0;
        else if (grant_valid && starve_cnt != STARVE_LAST)
          starve_cnt <= starve_cnt + 1'b1;
      end
      if (state == ADDR)
        tmo_cnt <= '0;
      else if (state == WAIT && !bus_ready && tmo_cnt != TMO_LAST)
        tmo_cnt <= tmo_cnt + 8'd1;
      if (resp_load) begin
        if (resp_m1) begin
          m1_err   <= resp_err;
          m1_rdata <= resp_rdata;
        end else begin
          m0_err   <= resp_err;
          m0_rdata <= resp_rdata;
        end
      end
    end
  end

  // The strobes are decoded from the state register so that an async reset
  // removes them at once.
  assign drive     = (state == ADDR) || (state == WAIT);
  assign bus_addr  = drive ? lat_addr  : '0;
  assign bus_wdata = drive ? lat_wdata : '0;
  assign bus_rd    = drive && lat_rd;
  assign bus_we    = drive ? lat_we : 4'h0;
  assign m0_done   = (state == RESP) && !owner;
  assign m1_done   = (state == RESP) && owner;

endmodule
